av_sync_counter_n: RTL and testbench

//  Parametrised synchronous up/down counter, successor to the fixed 4-bit C43 cell.
//  - Width is a multiple of 4, built by cascading 4-bit slices.
//  - Adds up/down mode and a programmable modulo with wrap-around.
//  - Carry/borrow out (CO) for cascading further instances.
//  - Used for video timing, address and tile counters in the K051962 simulation model.

---
 rtl/av_cell_pkg.sv | 18 +
 rtl/av_c43_slice.sv | 49 ++++
 rtl/av_sync_counter_n.sv | 71 +++++++
 tb/tb_av_sync_counter_n.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/av_cell_pkg.sv
`timescale 1ns/1ps
// av_cell_pkg: cell-library timing constants and the terminal-count helper shared by the av_* counters.
// The timing constants are only applied when AV_CELL_DLY_EN is defined.
package av_cell_pkg;

  localparam real T_CK_Q   = 8.37;
  localparam real T_CL_Q   = 5.54;
  localparam real T_CI_CO  = 4.07;
  localparam int  TC_MAX_W = 64;

  // Up: at the terminal value. Down: at zero.
  function automatic logic is_tc(input logic [TC_MAX_W-1:0] q,
                                 input logic [TC_MAX_W-1:0] tc,
                                 input logic                ud);
    return ud ? (q == tc) : (q == '0);
  endfunction

endpackage

// File: rtl/av_c43_slice.sv
`timescale 1ns/1ps
// av_c43_slice: 4-bit up/down counter cell with async clear, sync load and CI->CO cascade.
// Build option AV_CELL_DLY_EN adds the cell library's worst-case output delays.
module av_c43_slice
  import av_cell_pkg::*;
#(
  parameter logic [3:0] RST_VAL = 4'h0
) (
  input  logic       CK,
  input  logic       CLn,
  input  logic       Ln,
  input  logic       CI,
  input  logic       EN,
  input  logic       UD,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic       CO
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (!Ln) begin
      q_d = D;
    end else if (CI && EN) begin
      q_d = UD ? q_q + 4'd1 : q_q - 4'd1;
    end
  end

`ifdef AV_CELL_DLY_EN
  always_ff @(posedge CK or negedge CLn) begin
    if (!CLn) q_q <= #(T_CL_Q) RST_VAL;
    else      q_q <= #(T_CK_Q) q_d;
  end

  assign #(T_CI_CO) CO = CI & (UD ? (q_q == 4'hF) : (q_q == 4'h0));
`else
  always_ff @(posedge CK or negedge CLn) begin
    if (!CLn) q_q <= RST_VAL;
    else      q_q <= q_d;
  end

  assign CO = CI & (UD ? (q_q == 4'hF) : (q_q == 4'h0));
`endif

  assign Q = q_q;

endmodule

// File: rtl/av_sync_counter_n.sv
`timescale 1ns/1ps
// av_sync_counter_n: W-bit up/down modulo counter built from cascaded av_c43_slice cells.
// Build option AV_CELL_DLY_EN adds the cell library's worst-case output delays.
module av_sync_counter_n
  import av_cell_pkg::*;
#(
  parameter int           W       = 16,
  parameter logic [W-1:0] TC_VAL  = {W{1'b1}},
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         CK,
  input  logic         CLn,
  input  logic         Ln,
  input  logic         CI,
  input  logic         EN,
  input  logic         UD,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q,
  output logic         CO
);

  localparam int N          = W / 4;
  localparam bit FULL_RANGE = (TC_VAL == {W{1'b1}});

  if ((W % 4) != 0 || W < 4 || W > TC_MAX_W) begin : g_bad_width
    $error("av_sync_counter_n: W=%0d must be a multiple of 4 in 4..%0d", W, TC_MAX_W);
  end

  logic [N:0]   carry;
  logic         at_tc;
  logic         wrap;
  logic         slice_ln;
  logic         co_dec;
  logic [W-1:0] slice_d;

  assign at_tc = is_tc(TC_MAX_W'(Q), TC_MAX_W'(TC_VAL), UD);

  // The modulo wrap rides on the slices' load path: a count step taken at the
  // terminal value reloads 0 (up) or TC_VAL (down) instead of counting.
  assign wrap     = Ln & CI & EN & at_tc;
  assign slice_ln = Ln & ~wrap;
  assign slice_d  = !Ln ? D : (UD ? '0 : TC_VAL);
  assign carry[0] = CI;

  for (genvar k = 0; k < N; k++) begin : g_slice
    av_c43_slice #(
      .RST_VAL(RST_VAL[4*k +: 4])
    ) u_slice (
      .CK (CK),
      .CLn(CLn),
      .Ln (slice_ln),
      .CI (carry[k]),
      .EN (EN),
      .UD (UD),
      .D  (slice_d[4*k +: 4]),
      .Q  (Q[4*k +: 4]),
      .CO (carry[k+1])
    );
  end

`ifdef AV_CELL_DLY_EN
  assign #(T_CI_CO * N) co_dec = CI & at_tc;
`else
  assign co_dec = CI & at_tc;
`endif

  // With a full-range terminal value the slice carry chain already is the CO
  // equation, so the cascade ripple path is kept; otherwise Q is decoded.
  assign CO = FULL_RANGE ? carry[N] : co_dec;

endmodule

// File: tb/tb_av_sync_counter_n.sv
`timescale 1ns/1ps
// Scoreboard bench for av_sync_counter_n: an 8-bit modulo-10 instance and a 16-bit full-range instance.
module tb_av_sync_counter_n;

  localparam logic [7:0]  TC8  = 8'd9;
  localparam logic [15:0] TC16 = 16'hFFFF;

  logic        CK  = 1'b0;
  logic        CLn = 1'b1;
  logic        Ln  = 1'b1;
  logic        CI  = 1'b0;
  logic        EN  = 1'b0;
  logic        UD  = 1'b1;
  logic [7:0]  D8  = '0;
  logic [15:0] D16 = '0;
  logic [7:0]  Q8;
  logic [15:0] Q16;
  logic        CO8, CO16;

  typedef struct {
    logic [7:0]  q8;
    logic [15:0] q16;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [7:0]  m8  = '0;
  logic [15:0] m16 = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #50 CK = ~CK;

  av_sync_counter_n #(.W(8), .TC_VAL(TC8)) dut8 (
    .CK(CK), .CLn(CLn), .Ln(Ln), .CI(CI), .EN(EN), .UD(UD),
    .D(D8), .Q(Q8), .CO(CO8)
  );

  av_sync_counter_n #(.W(16)) dut16 (
    .CK(CK), .CLn(CLn), .Ln(Ln), .CI(CI), .EN(EN), .UD(UD),
    .D(D16), .Q(Q16), .CO(CO16)
  );

  function automatic logic [7:0] nxt8(input logic [7:0] q);
    if (!Ln) return D8;
    if (CI && EN) begin
      if (UD) return (q == TC8) ? 8'h00 : q + 8'h01;
      else    return (q == 8'h00) ? TC8 : q - 8'h01;
    end
    return q;
  endfunction

  function automatic logic [15:0] nxt16(input logic [15:0] q);
    if (!Ln) return D16;
    if (CI && EN) begin
      if (UD) return (q == TC16) ? 16'h0000 : q + 16'h0001;
      else    return (q == 16'h0000) ? TC16 : q - 16'h0001;
    end
    return q;
  endfunction

  // Push the expected post-edge values, then clock once and land well after all output delays.
  task automatic cycle();
    m8    = nxt8(m8);
    m16   = nxt16(m16);
    e.q8  = m8;
    e.q16 = m16;
    sb.push_back(e);
    @(posedge CK);
    #20;
  endtask

  task automatic test_reset();
    #5 CLn = 1'b0;
    #6;
    m8 = '0; m16 = '0;
    n_cmp++; if (Q8 !== 8'h00) begin n_err++; $display("FAIL reset_q8: got %h want %h", Q8, 8'h00); end
    n_cmp++; if (Q16 !== 16'h0000) begin n_err++; $display("FAIL reset_q16: got %h want %h", Q16, 16'h0000); end
    n_cmp++; if (CO8 !== 1'b0) begin n_err++; $display("FAIL reset_co8: got %b want %b", CO8, 1'b0); end
    @(posedge CK);
    #20;
    n_cmp++; if (Q8 !== 8'h00) begin n_err++; $display("FAIL reset_hold: got %h want %h", Q8, 8'h00); end
    CLn = 1'b1; CI = 1'b1; EN = 1'b1; UD = 1'b1;
    repeat (2) begin
      cycle(); e = sb.pop_front();
      n_cmp++; if (Q8 !== e.q8) begin n_err++; $display("FAIL reset_pre_count: got %h want %h", Q8, e.q8); end
    end
    CLn = 1'b0;
    #6;
    m8 = '0; m16 = '0;
    n_cmp++; if (Q8 !== 8'h00) begin n_err++; $display("FAIL midcycle_clear8: got %h want %h", Q8, 8'h00); end
    n_cmp++; if (Q16 !== 16'h0000) begin n_err++; $display("FAIL midcycle_clear16: got %h want %h", Q16, 16'h0000); end
    CLn = 1'b1;
    repeat (3) begin
      cycle(); e = sb.pop_front();
      n_cmp++; if (Q8 !== e.q8) begin n_err++; $display("FAIL reset_resume: got %h want %h", Q8, e.q8); end
    end
    n_cmp++; if (Q8 !== 8'h03) begin n_err++; $display("FAIL reset_three: got %h want %h", Q8, 8'h03); end
  endtask

  task automatic test_mod_up();
    CLn = 1'b0;
    #6;
    m8 = '0; m16 = '0;
    CLn = 1'b1; Ln = 1'b1; CI = 1'b1; EN = 1'b1; UD = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      cycle(); e = sb.pop_front();
      n_cmp++; if (Q8 !== e.q8) begin n_err++; $display("FAIL modup_q step %0d: got %h want %h", i, Q8, e.q8); end
      #30;
      n_cmp++; if (CO8 !== (m8 == TC8)) begin n_err++; $display("FAIL modup_co step %0d: got %b want %b", i, CO8, (m8 == TC8)); end
    end
    n_cmp++; if (Q8 !== 8'd9) begin n_err++; $display("FAIL modup_at_tc: got %h want %h", Q8, 8'd9); end
    CI = 1'b0;
    #30;
    n_cmp++; if (CO8 !== 1'b0) begin n_err++; $display("FAIL modup_co_noci: got %b want %b", CO8, 1'b0); end
    cycle(); e = sb.pop_front();
    n_cmp++; if (Q8 !== e.q8) begin n_err++; $display("FAIL modup_hold_noci: got %h want %h", Q8, e.q8); end
    CI = 1'b1;
    cycle(); e = sb.pop_front();
    n_cmp++; if (Q8 !== 8'h00) begin n_err++; $display("FAIL modup_wrap: got %h want %h", Q8, 8'h00); end
    n_cmp++; if (Q16 !== e.q16) begin n_err++; $display("FAIL modup_q16: got %h want %h", Q16, e.q16); end
  endtask

  task automatic test_mod_down();
    Ln = 1'b0; D8 = 8'h00; D16 = 16'h0000;
    cycle(); e = sb.pop_front();
    n_cmp++; if (Q8 !== e.q8) begin n_err++; $display("FAIL moddn_load0: got %h want %h", Q8, e.q8); end
    Ln = 1'b1; UD = 1'b0; CI = 1'b1; EN = 1'b1;
    #30;
    n_cmp++; if (CO8 !== 1'b1) begin n_err++; $display("FAIL moddn_borrow: got %b want %b", CO8, 1'b1); end
    cycle(); e = sb.pop_front();
    n_cmp++; if (Q8 !== 8'd9) begin n_err++; $display("FAIL moddn_wrap: got %h want %h", Q8, 8'd9); end
    #30;
    n_cmp++; if (CO8 !== 1'b0) begin n_err++; $display("FAIL moddn_co_fall: got %b want %b", CO8, 1'b0); end
    repeat (3) begin
      cycle(); e = sb.pop_front();
      n_cmp++; if (Q8 !== e.q8) begin n_err++; $display("FAIL moddn_step: got %h want %h", Q8, e.q8); end
    end
    UD = 1'b1;
    #30;
    n_cmp++; if (CO8 !== 1'b0) begin n_err++; $display("FAIL moddn_ud_flip_co: got %b want %b", CO8, 1'b0); end
    cycle(); e = sb.pop_front();
    n_cmp++; if (Q8 !== 8'd7) begin n_err++; $display("FAIL moddn_ud_flip_q: got %h want %h", Q8, 8'd7); end
  endtask

  task automatic test_load_priority();
    Ln = 1'b0; D8 = 8'h5A; D16 = 16'h1234; CI = 1'b1; EN = 1'b1; UD = 1'b1;
    cycle(); e = sb.pop_front();
    n_cmp++; if (Q8 !== 8'h5A) begin n_err++; $display("FAIL load_wins8: got %h want %h", Q8, 8'h5A); end
    n_cmp++; if (Q16 !== e.q16) begin n_err++; $display("FAIL load_wins16: got %h want %h", Q16, e.q16); end
    D8 = 8'hF0;
    cycle(); e = sb.pop_front();
    n_cmp++; if (Q8 !== 8'hF0) begin n_err++; $display("FAIL load_over_tc: got %h want %h", Q8, 8'hF0); end
    Ln = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      cycle(); e = sb.pop_front();
      n_cmp++; if (Q8 !== e.q8) begin n_err++; $display("FAIL over_tc_up step %0d: got %h want %h", i, Q8, e.q8); end
      #30;
      n_cmp++; if (CO8 !== 1'b0) begin n_err++; $display("FAIL over_tc_co step %0d: got %b want %b", i, CO8, 1'b0); end
    end
    n_cmp++; if (Q8 !== 8'h01) begin n_err++; $display("FAIL over_tc_wrap: got %h want %h", Q8, 8'h01); end
    Ln = 1'b0; D8 = 8'hF0;
    cycle(); e = sb.pop_front();
    Ln = 1'b1; UD = 1'b0;
    cycle(); e = sb.pop_front();
    n_cmp++; if (Q8 !== 8'hEF) begin n_err++; $display("FAIL over_tc_down: got %h want %h", Q8, 8'hEF); end
  endtask

  task automatic test_cascade();
    Ln = 1'b0; D16 = 16'h00FF; D8 = 8'h03; UD = 1'b1; CI = 1'b1; EN = 1'b1;
    cycle(); e = sb.pop_front();
    Ln = 1'b1;
    cycle(); e = sb.pop_front();
    n_cmp++; if (Q16 !== 16'h0100) begin n_err++; $display("FAIL casc_ripple: got %h want %h", Q16, 16'h0100); end
    #30;
    n_cmp++; if (CO16 !== 1'b0) begin n_err++; $display("FAIL casc_co_mid: got %b want %b", CO16, 1'b0); end
    Ln = 1'b0; D16 = 16'hFFFE;
    cycle(); e = sb.pop_front();
    Ln = 1'b1;
    #30;
    n_cmp++; if (CO16 !== 1'b0) begin n_err++; $display("FAIL casc_co_fffe: got %b want %b", CO16, 1'b0); end
    cycle(); e = sb.pop_front();
    n_cmp++; if (Q16 !== 16'hFFFF) begin n_err++; $display("FAIL casc_top: got %h want %h", Q16, 16'hFFFF); end
    #30;
    n_cmp++; if (CO16 !== 1'b1) begin n_err++; $display("FAIL casc_co_top: got %b want %b", CO16, 1'b1); end
    EN = 1'b0;
    #30;
    n_cmp++; if (CO16 !== 1'b1) begin n_err++; $display("FAIL casc_co_en0: got %b want %b", CO16, 1'b1); end
    cycle(); e = sb.pop_front();
    n_cmp++; if (Q16 !== 16'hFFFF) begin n_err++; $display("FAIL casc_hold_en0: got %h want %h", Q16, 16'hFFFF); end
    n_cmp++; if (Q8 !== e.q8) begin n_err++; $display("FAIL casc_hold_q8: got %h want %h", Q8, e.q8); end
    CI = 1'b0;
    #30;
    n_cmp++; if (CO16 !== 1'b0) begin n_err++; $display("FAIL casc_co_ci0: got %b want %b", CO16, 1'b0); end
    CI = 1'b1; EN = 1'b1;
    cycle(); e = sb.pop_front();
    n_cmp++; if (Q16 !== 16'h0000) begin n_err++; $display("FAIL casc_wrap: got %h want %h", Q16, 16'h0000); end
    #30;
    n_cmp++; if (CO16 !== 1'b0) begin n_err++; $display("FAIL casc_co_zero_up: got %b want %b", CO16, 1'b0); end
    UD = 1'b0;
    #30;
    n_cmp++; if (CO16 !== 1'b1) begin n_err++; $display("FAIL casc_co_zero_dn: got %b want %b", CO16, 1'b1); end
    cycle(); e = sb.pop_front();
    n_cmp++; if (Q16 !== 16'hFFFF) begin n_err++; $display("FAIL casc_down_wrap: got %h want %h", Q16, 16'hFFFF); end
    n_cmp++; if (Q8 !== e.q8) begin n_err++; $display("FAIL casc_q8: got %h want %h", Q8, e.q8); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mod_up();
    test_mod_down();
    test_load_priority();
    test_cascade();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
